// File: rtl/glorb_pkg.sv
// Shared opcode and state encodings for the execute stage.
package glorb_pkg;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_SHR = 3'd6;
   localparam logic [2:0] OP_MUL = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/exec_unit_alu_comb.sv
// Single-cycle ALU for ADD/SUB/AND/OR/XOR; c is carry-out or borrow.
module alu_comb
   import glorb_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [2:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] y,
   output logic          c
);

   always_comb begin
      y = '0;
      c = 1'b0;
      case (op)
         OP_ADD:  {c, y} = {1'b0, a} + {1'b0, b};
         OP_SUB:  {c, y} = {1'b0, a} - {1'b0, b};
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus iterative shift and shift-add multiply.
//   state | meaning
//   IDLE  | no result pending, ready to accept
//   RUN   | shift/MUL iterating, cnt_q steps remain
//   DONE  | result valid on wb_*, may accept the next op
module exec_unit
   import glorb_pkg::*;
#(
   parameter int DW  = 8,
   parameter int RFW = 2,
   parameter int IMW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2:0]     op,
   input  logic [RFW-1:0] rd,
   input  logic [DW-1:0]  a,
   input  logic [DW-1:0]  b,
   input  logic [IMW-1:0] imm,
   input  logic           use_imm,
   output logic           wb_we,
   output logic [RFW-1:0] wb_address,
   output logic [DW-1:0]  wb_data,
   output logic           flag_z,
   output logic           flag_c,
   output logic           busy
);

   localparam int LW = $clog2(DW);
   localparam int CW = LW + 1;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [RFW-1:0]   rd_q, rd_d;
   logic [2*DW-1:0]  work_q, work_d;
   logic [DW-1:0]    mpl_q, mpl_d;
   logic [2*DW-1:0]  acc_q, acc_d;
   logic             sc_q, sc_d;
   logic [DW-1:0]    wb_data_q, wb_data_d;
   logic [RFW-1:0]   wb_addr_q, wb_addr_d;
   logic             fz_q, fz_d;
   logic             fc_q, fc_d;

   logic             accept;
   logic [DW-1:0]    b_sel;
   logic [DW-1:0]    alu_y;
   logic             alu_c;
   logic [DW-1:0]    run_res;
   logic             run_c;

   assign accept = in_valid && in_ready;
   assign b_sel  = use_imm ? DW'(imm) : b;

   alu_comb #(.DW(DW)) u_alu (
      .op (op),
      .a  (a),
      .b  (b_sel),
      .y  (alu_y),
      .c  (alu_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         rd_q      <= '0;
         work_q    <= '0;
         mpl_q     <= '0;
         acc_q     <= '0;
         sc_q      <= 1'b0;
         wb_data_q <= '0;
         wb_addr_q <= '0;
         fz_q      <= 1'b0;
         fc_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         rd_q      <= rd_d;
         work_q    <= work_d;
         mpl_q     <= mpl_d;
         acc_q     <= acc_d;
         sc_q      <= sc_d;
         wb_data_q <= wb_data_d;
         wb_addr_q <= wb_addr_d;
         fz_q      <= fz_d;
         fc_q      <= fc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (accept) state_d = (op <= OP_XOR) ? S_DONE : S_RUN;
            else        state_d = S_IDLE;
         end
         S_RUN:   if (cnt_q == '0) state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
   end

   assign run_res = (op_q == OP_MUL) ? acc_q[DW-1:0] : work_q[DW-1:0];
   assign run_c   = (op_q == OP_MUL) ? (|acc_q[2*DW-1:DW]) : sc_q;

   always_comb begin
      cnt_d     = cnt_q;
      op_d      = op_q;
      rd_d      = rd_q;
      work_d    = work_q;
      mpl_d     = mpl_q;
      acc_d     = acc_q;
      sc_d      = sc_q;
      wb_data_d = wb_data_q;
      wb_addr_d = wb_addr_q;
      fz_d      = fz_q;
      fc_d      = fc_q;
      if (accept) begin
         op_d   = op;
         rd_d   = rd;
         work_d = {{DW{1'b0}}, a};
         mpl_d  = b_sel;
         acc_d  = '0;
         sc_d   = 1'b0;
         cnt_d  = (op == OP_MUL) ? CW'(DW) : {1'b0, b_sel[LW-1:0]};
         if (op <= OP_XOR) begin
            wb_data_d = alu_y;
            wb_addr_d = rd;
            fz_d      = (alu_y == '0);
            fc_d      = alu_c;
         end
      end else if (state_q == S_RUN) begin
         if (cnt_q == '0) begin
            wb_data_d = run_res;
            wb_addr_d = rd_q;
            fz_d      = (run_res == '0);
            fc_d      = run_c;
         end else begin
            cnt_d = cnt_q - 1'b1;
            case (op_q)
               OP_SHL: begin
                  sc_d   = work_q[DW-1];
                  work_d = {{DW{1'b0}}, work_q[DW-2:0], 1'b0};
               end
               OP_SHR: begin
                  sc_d   = work_q[0];
                  work_d = {{DW{1'b0}}, 1'b0, work_q[DW-1:1]};
               end
               default: begin
                  // multiplicand walks left while the multiplier drains right
                  if (mpl_q[0]) acc_d = acc_q + work_q;
                  work_d = {work_q[2*DW-2:0], 1'b0};
                  mpl_d  = {1'b0, mpl_q[DW-1:1]};
               end
            endcase
         end
      end
   end

   always_comb begin
      in_ready = ((state_q == S_IDLE) || (state_q == S_DONE)) && rst_n;
      busy     = (state_q == S_RUN);
      wb_we    = (state_q == S_DONE) && (rd_q != '0);
   end

   assign wb_address = wb_addr_q;
   assign wb_data    = wb_data_q;
   assign flag_z     = fz_q;
   assign flag_c     = fc_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed plus randomized checks of exec_unit against a arithmetic reference model.
module tb_exec_unit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] op;
   logic [1:0] rd;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] imm;
   logic       use_imm;
   logic       wb_we;
   logic [1:0] wb_address;
   logic [7:0] wb_data;
   logic       flag_z;
   logic       flag_c;
   logic       busy;

   int vectors = 0;
   int miscompares = 0;
   logic exp_z = 1'b0;
   logic exp_c = 1'b0;

   exec_unit #(.DW(8), .RFW(2), .IMW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .rd         (rd),
      .a          (a),
      .b          (b),
      .imm        (imm),
      .use_imm    (use_imm),
      .wb_we      (wb_we),
      .wb_address (wb_address),
      .wb_data    (wb_data),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: result, carry and latency straight from the operation definitions.
   task automatic model(input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] res, output logic c, output int lat);
      logic [15:0] full;
      int n;
      n = bv % 8;
      res = 8'h00; c = 1'b0; lat = 0;
      case (o)
         3'd0: begin full = 16'(av) + 16'(bv); res = full[7:0]; c = full[8]; end
         3'd1: begin res = 8'(av - bv); c = (av < bv); end
         3'd2: res = av & bv;
         3'd3: res = av | bv;
         3'd4: res = av ^ bv;
         3'd5: begin full = {8'h00, av} << n; res = full[7:0]; c = (n != 0) && full[8]; lat = n + 1; end
         3'd6: begin full = {av, 8'h00} >> n; res = full[15:8]; c = (n != 0) && full[7]; lat = n + 1; end
         default: begin full = 16'(av) * 16'(bv); res = full[7:0]; c = (full[15:8] != 0); lat = 9; end
      endcase
   endtask

   task automatic do_op(input logic [2:0] o, input logic [1:0] r, input logic [7:0] av,
                        input logic [7:0] bv, input logic [3:0] im, input logic ui);
      logic [7:0] bb, res;
      logic c;
      int lat;
      bb = ui ? {4'h0, im} : bv;
      model(o, av, bb, res, c, lat);
      @(negedge clk);
      in_valid = 1'b1; op = o; rd = r; a = av; b = bv; imm = im; use_imm = ui;
      chk("ready_before_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); imm = 4'($urandom); use_imm = 1'($urandom); rd = 2'($urandom);
      for (int k = 0; k <= lat; k++) begin
         if (k > 0) begin @(posedge clk); #1; end
         chk("wb_we", 32'(wb_we), 32'((k == lat) && (r != 0)));
         chk("busy", 32'(busy), 32'(k < lat));
         chk("in_ready", 32'(in_ready), 32'(k == lat));
         if (k == lat) begin
            exp_z = (res == 8'h00);
            exp_c = c;
            if (r != 0) begin
               chk("wb_data", 32'(wb_data), 32'(res));
               chk("wb_address", 32'(wb_address), 32'(r));
            end
         end
         chk("flag_z", 32'(flag_z), 32'(exp_z));
         chk("flag_c", 32'(flag_c), 32'(exp_c));
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wb_we"},  32'(wb_we), 32'd0);
      chk({tag, "_wb_data"}, 32'(wb_data), 32'd0);
      chk({tag, "_wb_addr"}, 32'(wb_address), 32'd0);
      chk({tag, "_flag_z"}, 32'(flag_z), 32'd0);
      chk({tag, "_flag_c"}, 32'(flag_c), 32'd0);
      chk({tag, "_busy"},   32'(busy), 32'd0);
      chk({tag, "_ready"},  32'(in_ready), 32'd0);
   endtask

   initial begin
      logic [7:0] xa [4];
      logic [7:0] xb [4];
      logic [1:0] xr [4];
      logic [7:0] res;
      logic c;
      int lat;

      rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; rd = 2'd0; a = 8'h00; b = 8'h00;
      imm = 4'h0; use_imm = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk_reset_outputs("reset");
      @(negedge clk); rst_n = 1'b1;

      do_op(3'd0, 2'd1, 8'hF0, 8'h20, 4'h0, 1'b0);
      do_op(3'd1, 2'd2, 8'h05, 8'hAA, 4'h5, 1'b1);
      do_op(3'd1, 2'd2, 8'h03, 8'h04, 4'h0, 1'b0);
      do_op(3'd5, 2'd3, 8'h81, 8'h03, 4'h0, 1'b0);
      do_op(3'd6, 2'd3, 8'h81, 8'h00, 4'h0, 1'b0);
      do_op(3'd7, 2'd1, 8'h13, 8'h11, 4'h0, 1'b0);
      do_op(3'd6, 2'd2, 8'h81, 8'h07, 4'h0, 1'b0);
      do_op(3'd7, 2'd0, 8'hFF, 8'hFF, 4'h0, 1'b0);

      // four back-to-back XORs, the last one to register 0
      xr[0] = 2'd1; xr[1] = 2'd2; xr[2] = 2'd3; xr[3] = 2'd0;
      xa[0] = 8'h5A; xa[1] = 8'h0F; xa[2] = 8'h33; xa[3] = 8'h77;
      xb[0] = 8'hA5; xb[1] = 8'h0F; xb[2] = 8'h12; xb[3] = 8'h77;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1; op = 3'd4; rd = xr[i]; a = xa[i]; b = xb[i]; use_imm = 1'b0;
         chk("b2b_ready", 32'(in_ready), 32'd1);
         @(posedge clk); #1;
         model(3'd4, xa[i], xb[i], res, c, lat);
         exp_z = (res == 8'h00); exp_c = c;
         chk("b2b_wb_we", 32'(wb_we), 32'(xr[i] != 0));
         if (xr[i] != 0) begin
            chk("b2b_wb_data", 32'(wb_data), 32'(res));
            chk("b2b_wb_addr", 32'(wb_address), 32'(xr[i]));
         end
         chk("b2b_flag_z", 32'(flag_z), 32'(exp_z));
         chk("b2b_flag_c", 32'(flag_c), 32'(exp_c));
      end
      @(negedge clk); in_valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b_idle_wb_we", 32'(wb_we), 32'd0);

      for (int i = 0; i < 40; i++)
         do_op(3'($urandom), 2'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));

      // MUL aborted by reset part-way through
      @(negedge clk);
      in_valid = 1'b1; op = 3'd7; rd = 2'd2; a = 8'h37; b = 8'h29; use_imm = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("abort_busy", 32'(busy), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1 chk_reset_outputs("abort");
      exp_z = 1'b0; exp_c = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         chk("abort_no_wb", 32'(wb_we), 32'd0);
      end
      do_op(3'd0, 2'd3, 8'h12, 8'h34, 4'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
